// File: rtl/pt_pkg.sv
// Shared types and constants for the PT2262-style encoder/decoder pair.
// Codebit encoding matches the encoder's ad input.
package pt_pkg;

  localparam logic [1:0] CB_ZERO  = 2'b00;
  localparam logic [1:0] CB_ONE   = 2'b01;
  localparam logic [1:0] CB_FLOAT = 2'b10;

  localparam int T_SHORT   = 4;
  localparam int T_LONG    = 12;
  localparam int T_CODEBIT = 32;
  localparam int T_SYNC    = 128;

  typedef enum logic [2:0] {
    HUNT,
    ARMED,
    MEAS_HIGH,
    MEAS_LOW,
    MEAS_SYNC
  } dec_state_t;

endpackage

// File: rtl/pt_dec_if.sv
// Serial line in, decoded word out.
// master drives the line, slave is the decoder.
interface pt_dec_if;
  logic        din;
  logic [23:0] word;
  logic        valid;
  logic        err;

  modport master (
    output din,
    input  word, valid, err
  );

  modport slave (
    input  din,
    output word, valid, err
  );
endinterface

// File: rtl/pt_pulse_meas.sv
// Line synchronizer, tick prescaler and saturating run-length counter.
// Emits edge events carrying the width of the run that just ended.
module pt_pulse_meas #(
  parameter int CLKS_PER_TICK = 1,
  parameter int SYNC_MIN      = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_din,
  output logic       o_tick,
  output logic       o_level,
  output logic       o_rise,
  output logic       o_fall,
  output logic [7:0] o_width,
  output logic [7:0] o_run,
  output logic       o_sync
);

  localparam int PW =
    (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;

  logic          r_s1;
  logic          r_s2;
  logic          r_lvl;
  logic [PW-1:0] r_pre;
  logic [7:0]    r_cnt;

  logic          w_edge;
  logic [7:0]    w_next;

  assign o_tick  = (r_pre == PW'(CLKS_PER_TICK - 1));
  assign w_edge  = (r_s2 != r_lvl);
  assign w_next  = w_edge ? 8'd1 :
                   (r_cnt == 8'hff) ? r_cnt :
                   r_cnt + 8'd1;

  assign o_level = r_s2;
  assign o_rise  = o_tick && w_edge && r_s2;
  assign o_fall  = o_tick && w_edge && !r_s2;
  assign o_width = r_cnt;
  assign o_run   = w_next;

  // Fire once per low run, even if the counter saturates at SYNC_MIN.
  assign o_sync  = o_tick && !r_s2 &&
                   (w_next == 8'(SYNC_MIN)) &&
                   (w_edge || r_cnt != 8'(SYNC_MIN));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_lvl <= 1'b0;
      r_pre <= '0;
      r_cnt <= 8'd0;
    end else begin
      r_s1  <= i_din;
      r_s2  <= r_s1;
      r_pre <= o_tick ? '0 : r_pre + PW'(1);
      if (o_tick) begin
        r_lvl <= r_s2;
        r_cnt <= w_next;
      end
    end
  end

endmodule

// File: rtl/pt_dec.sv
// PT2262-style frame decoder: half-bit FSM, codebit shifter
// and repeated-frame match filter.
module pt_dec
  import pt_pkg::*;
#(
  parameter int CLKS_PER_TICK = 1,
  parameter int REPEAT        = 2,
  parameter int SHORT_MIN     = 2,
  parameter int SHORT_MAX     = 7,
  parameter int LONG_MIN      = 9,
  parameter int LONG_MAX      = 15,
  parameter int SYNC_MIN      = 64
) (
  input  logic     clk,
  input  logic     rst,
  pt_dec_if.slave  bus
);

  logic       w_tick, w_level, w_rise, w_fall, w_sync;
  logic [7:0] w_width, w_run;

  pt_pulse_meas #(
    .CLKS_PER_TICK (CLKS_PER_TICK),
    .SYNC_MIN      (SYNC_MIN)
  ) u_meas (
    .clk     (clk),
    .rst     (rst),
    .i_din   (bus.din),
    .o_tick  (w_tick),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall),
    .o_width (w_width),
    .o_run   (w_run),
    .o_sync  (w_sync)
  );

  dec_state_t  r_state, w_state_nxt;
  logic [4:0]  r_halves;
  logic        r_first;
  logic        r_hi_long;
  logic [23:0] r_sr;
  logic [23:0] r_cand;
  logic [2:0]  r_mcnt;
  logic [23:0] r_word;
  logic        r_valid;
  logic        r_err;

  logic       w_s, w_l, w_over;
  logic       w_err, w_done, w_shift;
  logic [1:0] w_cb;
  logic       w_match, w_fire;
  logic [2:0] w_mcnt_nxt;

  assign w_s = (w_width >= 8'(SHORT_MIN)) &&
               (w_width <= 8'(SHORT_MAX));
  assign w_l = (w_width >= 8'(LONG_MIN)) &&
               (w_width <= 8'(LONG_MAX));
  assign w_over = w_tick && (w_run > 8'(LONG_MAX));

  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    w_done      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      HUNT:
        if (w_sync) w_state_nxt = ARMED;
      ARMED:
        if (w_rise) w_state_nxt = MEAS_HIGH;
      MEAS_HIGH:
        if (w_over && w_level) w_err = 1'b1;
        else if (w_fall) begin
          if (r_halves == 5'd24) begin
            if (w_s) w_state_nxt = MEAS_SYNC;
            else     w_err = 1'b1;
          end else if (w_s || w_l) begin
            w_state_nxt = MEAS_LOW;
          end else begin
            w_err = 1'b1;
          end
        end
      MEAS_LOW:
        if (w_over && !w_level) w_err = 1'b1;
        else if (w_rise) begin
          if (r_hi_long ? !w_s : !w_l) w_err = 1'b1;
          // Second half of a pair: 1 then 0 has no codebit.
          else if (r_halves[0] && r_first && !r_hi_long)
            w_err = 1'b1;
          else begin
            w_shift     = 1'b1;
            w_state_nxt = MEAS_HIGH;
          end
        end
      MEAS_SYNC:
        if (w_rise) w_err = 1'b1;
        else if (w_sync) begin
          w_done      = 1'b1;
          w_state_nxt = ARMED;
        end
      default:
        w_state_nxt = HUNT;
    endcase
    if (w_err) w_state_nxt = HUNT;
  end

  always_comb begin
    w_cb = CB_ZERO;
    unique case (1'b1)
      r_first && r_hi_long:  w_cb = CB_ONE;
      !r_first && r_hi_long: w_cb = CB_FLOAT;
      default:               w_cb = CB_ZERO;
    endcase
  end

  assign w_match    = (r_sr == r_cand);
  assign w_mcnt_nxt = !w_match ? 3'd1 :
                      (r_mcnt >= 3'(REPEAT)) ? r_mcnt :
                      r_mcnt + 3'd1;
  assign w_fire     = (w_mcnt_nxt == 3'(REPEAT)) &&
                      (!w_match || r_mcnt != 3'(REPEAT));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= HUNT;
      r_halves  <= 5'd0;
      r_first   <= 1'b0;
      r_hi_long <= 1'b0;
      r_sr      <= 24'd0;
      r_cand    <= 24'd0;
      r_mcnt    <= 3'd0;
      r_word    <= 24'd0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= 1'b0;
      r_err   <= w_err;
      if (w_err) r_mcnt <= 3'd0;
      if (r_state == ARMED) begin
        r_halves <= 5'd0;
        r_sr     <= 24'd0;
      end
      if (r_state == MEAS_HIGH && w_fall) r_hi_long <= w_l;
      if (w_shift) begin
        r_halves <= r_halves + 5'd1;
        if (!r_halves[0]) r_first <= r_hi_long;
        else              r_sr <= {r_sr[21:0], w_cb};
      end
      if (w_done) begin
        r_cand <= r_sr;
        r_mcnt <= w_mcnt_nxt;
        if (w_fire) begin
          r_word  <= r_sr;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign bus.word  = r_word;
  assign bus.valid = r_valid;
  assign bus.err   = r_err;

endmodule

// File: tb/tb_pt_dec.sv
// Directed bench for pt_dec: behavioural PT2262 line encoder
// driving three decoder configurations.
module tb_pt_dec;
  import pt_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pt_dec_if b1 ();
  pt_dec_if b4 ();
  pt_dec_if b2 ();

  pt_dec #(.CLKS_PER_TICK(1), .REPEAT(1)) u1 (
    .clk(clk), .rst(rst), .bus(b1)
  );
  pt_dec #(.CLKS_PER_TICK(4), .REPEAT(1)) u4 (
    .clk(clk), .rst(rst), .bus(b4)
  );
  pt_dec #(.CLKS_PER_TICK(1), .REPEAT(2)) u2 (
    .clk(clk), .rst(rst), .bus(b2)
  );

  int checks = 0;
  int errors = 0;
  int vc[3];
  int ec[3];

  typedef struct {
    logic [23:0] ad;
    int          kind;
    int          nval;
    int          nerr;
    logic [23:0] word;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (b1.valid) vc[0]++;
    if (b1.err)   ec[0]++;
    if (b4.valid) vc[1]++;
    if (b4.err)   ec[1]++;
    if (b2.valid) vc[2]++;
    if (b2.err)   ec[2]++;
    if (b1.valid || b1.err)
      chk("u1_err_valid_excl", {31'd0, b1.valid & b1.err}, 32'd0);
    if (b2.valid || b2.err)
      chk("u2_err_valid_excl", {31'd0, b2.valid & b2.err}, 32'd0);
  end

  task automatic set_din(input int w, input logic v);
    case (w)
      0:       b1.din = v;
      1:       b4.din = v;
      default: b2.din = v;
    endcase
  endtask

  task automatic hold(input int w, input logic v, input int ticks);
    set_din(w, v);
    repeat (ticks * ((w == 1) ? 4 : 1)) @(negedge clk);
  endtask

  // kind: 0 clean, 1 half 4 high=8, 2 half 9 low=20,
  // 3 sync pulse long, 4 sync gap cut short, 5 reset after 10 halves
  task automatic send_frame(input int w, input logic [23:0] ad,
                            input int kind);
    logic [1:0] cb;
    logic       h;
    int         hi, lo;
    for (int i = 0; i < 24; i++) begin
      cb = 2'(ad >> (22 - 2 * (i / 2)));
      h  = (cb == 2'b01) ||
           (cb == 2'b11 && i % 2 == 0) ||
           (cb == 2'b10 && i % 2 == 1);
      hi = h ? T_LONG : T_SHORT;
      lo = T_CODEBIT / 2 - hi;
      if (kind == 1 && i == 4) hi = 8;
      if (kind == 2 && i == 9) lo = 20;
      if (kind == 5 && i == 10) begin
        rst = 1'b1;
        @(negedge clk);
        chk("rst_word", {8'd0, b1.word}, 32'd0);
        chk("rst_valid", {31'd0, b1.valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
      end
      hold(w, 1'b1, hi);
      hold(w, 1'b0, lo);
    end
    hold(w, 1'b1, (kind == 3) ? T_LONG : T_SHORT);
    if (kind == 4) begin
      hold(w, 1'b0, 40);
      hold(w, 1'b1, T_SHORT);
    end
    hold(w, 1'b0, T_SYNC - T_SHORT);
  endtask

  logic [23:0] sa[5];
  int          sv[5];
  logic [23:0] sw[5];
  int          pv, pe;

  initial begin
    tv[0]  = '{24'h000000, 0, 1, 0, 24'h000000};
    tv[1]  = '{24'h916A24, 0, 1, 0, 24'h916A24};
    tv[2]  = '{24'h916A24, 0, 0, 0, 24'h916A24};
    tv[3]  = '{24'h555555, 1, 0, 1, 24'h916A24};
    tv[4]  = '{24'h916A24, 0, 1, 0, 24'h916A24};
    tv[5]  = '{24'h030000, 0, 0, 1, 24'h916A24};
    tv[6]  = '{24'h2A6912, 0, 1, 0, 24'h2A6912};
    tv[7]  = '{24'h2A6912, 2, 0, 1, 24'h2A6912};
    tv[8]  = '{24'h2A6912, 3, 0, 1, 24'h2A6912};
    tv[9]  = '{24'h2A6912, 4, 0, 1, 24'h2A6912};
    tv[10] = '{24'h2A6912, 0, 1, 0, 24'h2A6912};
    tv[11] = '{24'h555555, 0, 1, 0, 24'h555555};

    sa = '{24'h916A24, 24'h916A24, 24'h916A24, 24'h000000, 24'h000000};
    sv = '{0, 1, 0, 0, 1};
    sw = '{24'h000000, 24'h916A24, 24'h916A24, 24'h916A24, 24'h000000};

    for (int i = 0; i < 3; i++) begin
      vc[i] = 0;
      ec[i] = 0;
    end
    b1.din = 1'b0;
    b4.din = 1'b0;
    b2.din = 1'b0;

    repeat (4) @(negedge clk);
    chk("reset_word", {8'd0, b1.word}, 32'd0);
    chk("reset_valid", {31'd0, b1.valid}, 32'd0);
    chk("reset_err", {31'd0, b1.err}, 32'd0);
    chk("reset_word_u2", {8'd0, b2.word}, 32'd0);
    rst = 1'b0;

    hold(0, 1'b0, 130);
    chk("idle_valid", vc[0], 0);

    for (int k = 0; k < 12; k++) begin
      pv = vc[0];
      pe = ec[0];
      send_frame(0, tv[k].ad, tv[k].kind);
      repeat (8) @(negedge clk);
      chk($sformatf("v%0d_valid", k), vc[0] - pv, tv[k].nval);
      chk($sformatf("v%0d_err", k), ec[0] - pe, tv[k].nerr);
      chk($sformatf("v%0d_word", k), {8'd0, b1.word},
          {8'd0, tv[k].word});
    end

    pv = vc[1];
    pe = ec[1];
    send_frame(1, 24'h916A24, 0);
    repeat (16) @(negedge clk);
    chk("div4_valid", vc[1] - pv, 1);
    chk("div4_err", ec[1] - pe, 0);
    chk("div4_word", {8'd0, b4.word}, 32'h916A24);

    for (int k = 0; k < 5; k++) begin
      pv = vc[2];
      send_frame(2, sa[k], 0);
      repeat (8) @(negedge clk);
      chk($sformatf("rep2_f%0d_valid", k), vc[2] - pv, sv[k]);
      chk($sformatf("rep2_f%0d_word", k), {8'd0, b2.word},
          {8'd0, sw[k]});
    end
    chk("rep2_err", ec[2], 0);

    pv = vc[0];
    pe = ec[0];
    send_frame(0, 24'h916A24, 5);
    repeat (8) @(negedge clk);
    chk("rst_frame1_valid", vc[0] - pv, 0);
    chk("rst_frame1_word", {8'd0, b1.word}, 32'd0);
    send_frame(0, 24'h2A6912, 0);
    repeat (8) @(negedge clk);
    chk("rst_frame2_valid", vc[0] - pv, 1);
    chk("rst_frame2_word", {8'd0, b1.word}, 32'h2A6912);
    chk("rst_err", ec[0] - pe, 0);

    pv = vc[0];
    pe = ec[0];
    hold(0, 1'b1, 40);
    chk("stuck_high_err", ec[0] - pe, 1);
    hold(0, 1'b0, 130);
    chk("stuck_high_err_once", ec[0] - pe, 1);
    chk("stuck_high_valid", vc[0] - pv, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/pt_dec.md
Name: pt_dec

Overview:
PT2262-style frame decoder that recovers the 24-bit address/data word from the serial line produced by pt_enc, either over the RF link or in loopback. Output uses the same 2-bit codebit encoding as the pt_enc ad input: 00 is zero, 01 is one, 10 is float. It sits downstream of pt_enc (receiver side), measures pulse widths, checks frame structure, and can require repeated identical frames before reporting a word.

Parameters:
CLKS_PER_TICK, 1, clk cycles per sampling tick; one tick equals one pt_enc clock.
REPEAT, 2, consecutive identical frames (1..7) required before valid.
SHORT_MIN, 2, minimum short-pulse width in ticks.
SHORT_MAX, 7, maximum short-pulse width in ticks.
LONG_MIN, 9, minimum long-pulse width in ticks.
LONG_MAX, 15, maximum long-pulse width in ticks.
SYNC_MIN, 64, minimum low run (ticks, at most 255) that marks a sync gap.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
din  in  1  asynchronous serial line from the pt_enc output or RF receiver
word  out  24  last accepted word; codebit 0 in [23:22]
valid  out  1  one-clk pulse when word updates
err  out  1  one-clk pulse on any frame-format violation

Behaviour:
- Reset: word=0, valid=0, err=0; state HUNT; all counters, prescaler, match count and 2-FF synchronizer cleared.
- Input path:
  - din passes through a 2-FF synchronizer.
  - A free-running prescaler issues one tick every CLKS_PER_TICK clks.
  - All width counting happens on ticks; width counters are 8-bit and saturate at 255.
- Width classes:
  - S: high or low run of SHORT_MIN..SHORT_MAX ticks.
  - L: run of LONG_MIN..LONG_MAX ticks.
  - Any other width is invalid.
- Half-bit rules:
  - A half-bit is a high run followed by a low run.
  - High S must pair with low L, giving half value 0 (4h/12l).
  - High L must pair with low S, giving half value 1 (12h/4l).
- Codebit mapping, 2 halves per codebit:
  - 00 gives 00.
  - 11 gives 01.
  - 01 gives 10 (float).
  - 10 is an error.
- State machine:
  - HUNT: count the low run; a high sample clears the count. Count reaching SYNC_MIN: go to ARMED.
  - ARMED: clear the half counter (0..24) and the shift register. Rising sample: go to MEAS_HIGH.
  - MEAS_HIGH: count high ticks.
    - High count exceeding LONG_MAX: error.
    - Falling sample with fewer than 24 halves: classify; an invalid width is an error; otherwise go to MEAS_LOW.
    - Falling sample with 24 halves: the sync pulse must be S (else error); go to MEAS_SYNC.
  - MEAS_LOW: count low ticks; exceeding LONG_MAX is an error.
    - Rising sample: low width must be the complement class of the preceding high (else error).
    - Then shift the half value in and increment the half counter.
    - On every even half count, check the pair (10 is an error) and load the mapped codebit.
    - Then go to MEAS_HIGH.
  - MEAS_SYNC: a rising sample before SYNC_MIN is an error. Low count reaching SYNC_MIN means frame complete: run the match logic, then go to ARMED (the gap doubles as the next frame's lead-in).
- Error handling: err pulses for 1 clk, match count is cleared, state goes to HUNT.
- Match logic:
  - Completed frame equal to the stored candidate: match count increments, saturating at REPEAT.
  - Otherwise: candidate is replaced and count set to 1.
  - When the count becomes exactly REPEAT: word is loaded with the candidate and valid pulses on the next clk.
  - Further identical frames produce no additional valid until a different frame or an error intervenes.
  - With REPEAT=1, every completed frame that differs from the previous candidate gives valid.
- Latency: valid and word update 1 clk after the tick on which the sync low count reaches SYNC_MIN. End-to-end adds 2 synchronizer clks.
- Simultaneous events: error detection takes priority over frame completion in the same tick. err and valid are never asserted together.
- Line stuck high: error after LONG_MAX+1 high ticks, then HUNT holds (low run count stays 0).
- Line stuck low: ARMED is reached and held; no outputs.
- rst mid-frame: the partial frame is discarded; after release, decoding restarts from HUNT and needs a full sync gap before accepting data.

Decomposition:
- Shared package pt_pkg holds:
  - codebit constants CB_ZERO=2'b00, CB_ONE=2'b01, CB_FLOAT=2'b10;
  - encoder timing constants T_SHORT=4, T_LONG=12, T_CODEBIT=32, T_SYNC=128 ticks;
  - the decoder state enum.
- Sub-module pt_pulse_meas contains the synchronizer, prescaler and high/low run counters. It emits edge events with the measured width and a low-run-reached-SYNC_MIN flag.
- The pt_dec top holds the FSM, shift register and match logic.

Test Plan:
- REPEAT=1, CLKS_PER_TICK=1: pt_enc looped to din with ad=24'h000000 -> after the first frame with a preceding gap, valid one clk, word=24'h000000, err never asserted.
- REPEAT=1, CLKS_PER_TICK=4: din driven from pt_enc clocked at clk/4 with ad=24'h916A24 -> valid once, word=24'h916A24.
- REPEAT=2: frames A,A,A,B,B with A=24'h916A24, B=24'h000000 -> valid after the 2nd A (word=A) and after the 2nd B (word=B) only; no valid on the 3rd A.
- REPEAT=1: 5th half-bit high stretched to 8 ticks -> err pulse, no valid; next clean frame after a sync gap gives valid.
- REPEAT=1: codebit 3 driven as halves L then S (pair 10) -> err pulse at the 8th half, no valid for that frame.
- rst asserted for 3 clks after 10 halves of frame 1 -> word=0, valid=0 during reset; frame 1 ignored; frame 2 decodes with valid and correct word.
